// File: rtl/mem_port_pkg.sv
// Shared types, funct3 encodings and helper functions for the byte-serial memory port controller.
package mem_port_pkg;

    localparam logic [2:0] SEL_B  = 3'b000;
    localparam logic [2:0] SEL_H  = 3'b001;
    localparam logic [2:0] SEL_W  = 3'b010;
    localparam logic [2:0] SEL_BU = 3'b100;
    localparam logic [2:0] SEL_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    function automatic logic [2:0] byte_count(input logic [2:0] sel);
        logic [2:0] n;
        case (sel)
            SEL_B, SEL_BU: n = 3'd1;
            SEL_H, SEL_HU: n = 3'd2;
            SEL_W:         n = 3'd4;
            default:       n = 3'd1;
        endcase
        return n;
    endfunction

    // Unsigned widths exist only for loads; stores accept B/H/W alone.
    function automatic logic sel_legal(input logic [2:0] sel, input logic we);
        logic ok;
        case (sel)
            SEL_B, SEL_H, SEL_W: ok = 1'b1;
            SEL_BU, SEL_HU:      ok = ~we;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] sel, input logic [31:0] w);
        logic [31:0] r;
        case (sel)
            SEL_B:   r = {{24{w[7]}}, w[7:0]};
            SEL_H:   r = {{16{w[15]}}, w[15:0]};
            SEL_BU:  r = {24'h000000, w[7:0]};
            SEL_HU:  r = {16'h0000, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Byte (n-1-idx) of right-aligned data, so the most significant byte leaves first.
    function automatic logic [7:0] store_byte(input logic [31:0] d, input logic [2:0] n,
                                              input logic [1:0] idx);
        logic [2:0] pos;
        logic [7:0] b;
        pos = n - 3'd1 - {1'b0, idx};
        case (pos)
            3'd0:    b = d[7:0];
            3'd1:    b = d[15:8];
            3'd2:    b = d[23:16];
            3'd3:    b = d[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_arb2.sv
// Two-way grant logic for the IF and LS requesters.
// ARB_RR_EN selects round-robin; otherwise LS has fixed priority over IF.
module mem_arb2
    import mem_port_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en,
    input  logic req_if,
    input  logic req_ls,
    output logic gnt_if,
    output logic gnt_ls
);

    logic pick_ls_s;

`ifdef ARB_RR_EN
    owner_e last_q;
    owner_e last_d;

    // Round-robin choice: the owner granted last yields on a tie.
    always_comb begin
        pick_ls_s = 1'b0;
        if (req_ls && req_if) begin
            pick_ls_s = (last_q == OWN_IF);
        end else begin
            pick_ls_s = req_ls;
        end
    end

    // Pointer next value follows whichever grant is issued.
    always_comb begin
        last_d = last_q;
        if (gnt_ls) begin
            last_d = OWN_LS;
        end else if (gnt_if) begin
            last_d = OWN_IF;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; resets to "IF last" so LS wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: LS wins whenever it requests.
    always_comb begin
        pick_ls_s = 1'b0;
        if (req_ls) begin
            pick_ls_s = 1'b1;
        end else begin
            pick_ls_s = 1'b0;
        end
    end
`endif

    assign gnt_ls = en & req_ls & pick_ls_s;
    assign gnt_if = en & req_if & ~pick_ls_s;

endmodule

// File: rtl/mem_port_ctrl.sv
// Shares one byte-wide memory between instruction fetch and load/store, one byte per cycle, big-endian.
// Build option: define ARB_RR_EN for round-robin arbitration (default is fixed LS priority).
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_we,
    input  logic [2:0]        ls_sel,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_resp_valid,
    output logic [31:0]       ls_rdata,
    output logic              ls_resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e            state_q,  state_d;
    owner_e            owner_q,  owner_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [2:0]        sel_q,    sel_d;
    logic              we_q,     we_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [1:0]        idx_q,    idx_d;
    logic [31:0]       asm_q,    asm_d;

    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_we_q,    mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              if_resp_valid_q, if_resp_valid_d;
    logic [31:0]       if_rdata_q,      if_rdata_d;
    logic              ls_resp_valid_q, ls_resp_valid_d;
    logic [31:0]       ls_rdata_q,      ls_rdata_d;
    logic              ls_resp_err_q,   ls_resp_err_d;

    logic              gnt_if_s, gnt_ls_s, acc_s, arb_en_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic [2:0]        req_sel_s;
    logic              req_we_s;
    logic [31:0]       req_wdata_s;
    logic [2:0]        n_s;
    logic              last_s;

    assign arb_en_s = rst_n & (state_q == IDLE);
    assign acc_s    = gnt_if_s | gnt_ls_s;

    mem_arb2 u_arb (
`ifdef ARB_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .en     (arb_en_s),
        .req_if (if_req_valid),
        .req_ls (ls_req_valid),
        .gnt_if (gnt_if_s),
        .gnt_ls (gnt_ls_s)
    );

    // Fetches always look like a legal word load.
    assign req_addr_s  = gnt_ls_s ? ls_addr  : if_addr;
    assign req_sel_s   = gnt_ls_s ? ls_sel   : SEL_W;
    assign req_we_s    = gnt_ls_s ? ls_we    : 1'b0;
    assign req_wdata_s = gnt_ls_s ? ls_wdata : 32'h00000000;

    assign n_s    = byte_count(sel_q);
    assign last_s = ({1'b0, idx_q} == (n_s - 3'd1));

    // Next-state, memory strobe and response computation; memory-side outputs are
    // computed one edge ahead so they are registered yet line up with the XFER cycle.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        sel_d           = sel_q;
        we_d            = we_q;
        wdata_d         = wdata_q;
        idx_d           = idx_q;
        asm_d           = asm_q;
        mem_addr_d      = {ADDR_W{1'b0}};
        mem_we_d        = 1'b0;
        mem_wdata_d     = 8'h00;
        if_resp_valid_d = 1'b0;
        if_rdata_d      = 32'h00000000;
        ls_resp_valid_d = 1'b0;
        ls_rdata_d      = 32'h00000000;
        ls_resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_s) begin
                    owner_d = gnt_ls_s ? OWN_LS : OWN_IF;
                    addr_d  = req_addr_s;
                    sel_d   = req_sel_s;
                    we_d    = req_we_s;
                    wdata_d = req_wdata_s;
                    idx_d   = 2'd0;
                    asm_d   = 32'h00000000;
                    if (sel_legal(req_sel_s, req_we_s)) begin
                        state_d     = XFER;
                        mem_addr_d  = req_addr_s;
                        mem_we_d    = req_we_s;
                        mem_wdata_d = req_we_s ? store_byte(req_wdata_s, byte_count(req_sel_s), 2'd0)
                                               : 8'h00;
                    end else begin
                        state_d         = RESP;
                        ls_resp_valid_d = 1'b1;
                        ls_resp_err_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                asm_d = {asm_q[23:0], mem_rdata};
                if (last_s) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) begin
                        if_resp_valid_d = 1'b1;
                        if_rdata_d      = asm_d;
                    end else begin
                        ls_resp_valid_d = 1'b1;
                        ls_rdata_d      = we_q ? 32'h00000000 : load_extend(sel_q, asm_d);
                    end
                end else begin
                    idx_d       = idx_q + 2'd1;
                    mem_addr_d  = addr_q + {{(ADDR_W-2){1'b0}}, idx_d};
                    mem_we_d    = we_q;
                    mem_wdata_d = we_q ? store_byte(wdata_q, n_s, idx_d) : 8'h00;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer and silences every output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            owner_q         <= OWN_IF;
            addr_q          <= {ADDR_W{1'b0}};
            sel_q           <= 3'b000;
            we_q            <= 1'b0;
            wdata_q         <= 32'h00000000;
            idx_q           <= 2'd0;
            asm_q           <= 32'h00000000;
            mem_addr_q      <= {ADDR_W{1'b0}};
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= 8'h00;
            if_resp_valid_q <= 1'b0;
            if_rdata_q      <= 32'h00000000;
            ls_resp_valid_q <= 1'b0;
            ls_rdata_q      <= 32'h00000000;
            ls_resp_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            addr_q          <= addr_d;
            sel_q           <= sel_d;
            we_q            <= we_d;
            wdata_q         <= wdata_d;
            idx_q           <= idx_d;
            asm_q           <= asm_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_rdata_q      <= if_rdata_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            ls_rdata_q      <= ls_rdata_d;
            ls_resp_err_q   <= ls_resp_err_d;
        end
    end

    assign if_req_ready  = gnt_if_s;
    assign ls_req_ready  = gnt_ls_s;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;
    assign if_resp_valid = if_resp_valid_q;
    assign if_rdata      = if_rdata_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign ls_rdata      = ls_rdata_q;
    assign ls_resp_err   = ls_resp_err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed self-checking bench for mem_port_ctrl with a behavioural byte memory.
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = 32'h0;
    logic        if_resp_valid;
    logic [31:0] if_rdata;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic        ls_we = 1'b0;
    logic [2:0]  ls_sel = 3'b000;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic        ls_resp_valid;
    logic [31:0] ls_rdata;
    logic        ls_resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:4095];
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_port_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
        .ls_sel(ls_sel), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[11:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one LS request, waits for its acceptance, and returns cycles from accept to response (-1 on timeout).
    task automatic ls_issue(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat);
        int guard;
        guard = 0;
        ls_req_valid = 1'b1; ls_we = we; ls_sel = sel; ls_addr = addr; ls_wdata = wdata;
        #1;
        while (!ls_req_ready && guard < 20) begin tick(); guard++; end
        tick();
        ls_req_valid = 1'b0;
        lat = 1;
        while (!ls_resp_valid && lat < 20) begin tick(); lat++; end
        if (!ls_resp_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_tests++;
        if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, ls_resp_err, mem_we} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
                {if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, ls_resp_err, mem_we});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== 104'h0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", mem_addr, mem_wdata, if_rdata, ls_rdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_arb_priority();
        int guard;
        ls_req_valid = 1'b1; ls_we = 1'b0; ls_sel = 3'b000; ls_addr = 32'h100;
        if_req_valid = 1'b1; if_addr = 32'h100;
        #1;
        n_tests++;
        if ({ls_req_ready, if_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL arb_first: got ls/if %b want 10", {ls_req_ready, if_req_ready});
        end
        tick();
        ls_req_valid = 1'b0;
        #1;
        n_tests++;
        if (if_req_ready !== 1'b0) begin n_fail++; $display("FAIL arb_xfer_ready: got %b want 0", if_req_ready); end
        tick();
        n_tests++;
        if ({ls_resp_valid, if_req_ready, ls_rdata} !== {2'b10, 32'hFFFFFF80}) begin
            n_fail++; $display("FAIL arb_ls_resp: got %b %b %h want 1 0 ffffff80", ls_resp_valid, if_req_ready, ls_rdata);
        end
        tick();
        n_tests++;
        if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL arb_if_grant: got %b want 1", if_req_ready); end
        tick();
        if_req_valid = 1'b0;
        guard = 0;
        while (!if_resp_valid && guard < 20) begin tick(); guard++; end
        n_tests++;
        if (if_rdata !== 32'h80123456 || !if_resp_valid) begin
            n_fail++; $display("FAIL arb_if_data: got %h want 80123456", if_rdata);
        end
        tick();
    endtask

    task automatic test_both_held();
        int g [3];
        int exp_g [3];
        int cnt;
        int cyc;
        int both;
`ifdef ARB_RR_EN
        exp_g = '{1, 2, 1};
`else
        exp_g = '{1, 1, 1};
`endif
        g = '{0, 0, 0};
        cnt = 0; cyc = 0; both = 0;
        ls_req_valid = 1'b1; ls_we = 1'b0; ls_sel = 3'b000; ls_addr = 32'h100;
        if_req_valid = 1'b1; if_addr = 32'h100;
        #1;
        while (cnt < 3 && cyc < 60) begin
            if (ls_req_ready && if_req_ready) both++;
            if (ls_req_ready) begin g[cnt] = 1; cnt++; end
            else if (if_req_ready) begin g[cnt] = 2; cnt++; end
            tick();
            cyc++;
        end
        ls_req_valid = 1'b0; if_req_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_tests++;
        if (g[0] !== exp_g[0] || g[1] !== exp_g[1] || g[2] !== exp_g[2] || both != 0) begin
            n_fail++; $display("FAIL both_held: got %0d %0d %0d (dual=%0d) want %0d %0d %0d",
                g[0], g[1], g[2], both, exp_g[0], exp_g[1], exp_g[2]);
        end
    endtask

    task automatic test_loads();
        int lat;
        ls_issue(1'b0, 3'b000, 32'h100, 32'h0, lat);
        n_tests++;
        if (lat != 2 || ls_rdata !== 32'hFFFFFF80 || ls_resp_err !== 1'b0) begin
            n_fail++; $display("FAIL load_b: got lat %0d data %h want lat 2 data ffffff80", lat, ls_rdata);
        end
        tick();
        ls_issue(1'b0, 3'b101, 32'h100, 32'h0, lat);
        n_tests++;
        if (lat != 3 || ls_rdata !== 32'h00008012) begin
            n_fail++; $display("FAIL load_hu: got lat %0d data %h want lat 3 data 00008012", lat, ls_rdata);
        end
        tick();
        ls_issue(1'b0, 3'b001, 32'h101, 32'h0, lat);
        n_tests++;
        if (lat != 3 || ls_rdata !== 32'h00001234) begin
            n_fail++; $display("FAIL load_h: got lat %0d data %h want lat 3 data 00001234", lat, ls_rdata);
        end
        tick();
        ls_issue(1'b0, 3'b100, 32'h100, 32'h0, lat);
        n_tests++;
        if (lat != 2 || ls_rdata !== 32'h00000080) begin
            n_fail++; $display("FAIL load_bu: got lat %0d data %h want lat 2 data 00000080", lat, ls_rdata);
        end
        tick();
    endtask

    task automatic test_fetch();
        logic [31:0] a;
        if_req_valid = 1'b1; if_addr = 32'h100;
        #1;
        n_tests++;
        if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready: got %b want 1", if_req_ready); end
        tick();
        if_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h100 + i;
            n_tests++;
            if (mem_addr !== a || mem_we !== 1'b0) begin
                n_fail++; $display("FAIL fetch_addr%0d: got %h we %b want %h we 0", i, mem_addr, mem_we, a);
            end
            tick();
        end
        n_tests++;
        if (if_resp_valid !== 1'b1 || if_rdata !== 32'h80123456 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL fetch_resp: got v %b data %h addr %h want 1 80123456 0", if_resp_valid, if_rdata, mem_addr);
        end
        tick();
        n_tests++;
        if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: got %b want 0", if_resp_valid); end
    endtask

    task automatic test_store_half();
        ls_req_valid = 1'b1; ls_we = 1'b1; ls_sel = 3'b001; ls_addr = 32'h200; ls_wdata = 32'hAAAABEEF;
        #1;
        tick();
        ls_req_valid = 1'b0;
        n_tests++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h200, 8'hBE}) begin
            n_fail++; $display("FAIL store_b0: got %b %h %h want 1 200 be", mem_we, mem_addr, mem_wdata);
        end
        tick();
        n_tests++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h201, 8'hEF}) begin
            n_fail++; $display("FAIL store_b1: got %b %h %h want 1 201 ef", mem_we, mem_addr, mem_wdata);
        end
        tick();
        n_tests++;
        if ({ls_resp_valid, ls_resp_err, mem_we, ls_rdata} !== {3'b100, 32'h0}) begin
            n_fail++; $display("FAIL store_resp: got v%b e%b we%b d%h want 1 0 0 0", ls_resp_valid, ls_resp_err, mem_we, ls_rdata);
        end
        n_tests++;
        if ({mem[12'h200], mem[12'h201]} !== 16'hBEEF) begin
            n_fail++; $display("FAIL store_mem: got %h%h want beef", mem[12'h200], mem[12'h201]);
        end
        tick();
    endtask

    task automatic test_store_wrap();
        int lat;
        ls_issue(1'b1, 3'b010, 32'hFFFFFFFF, 32'hCAFEF00D, lat);
        n_tests++;
        if (lat != 5 || {mem[12'hFFF], mem[12'h000], mem[12'h001], mem[12'h002]} !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL store_wrap: got lat %0d mem %h%h%h%h want lat 5 cafef00d",
                lat, mem[12'hFFF], mem[12'h000], mem[12'h001], mem[12'h002]);
        end
        tick();
    endtask

    task automatic test_illegal();
        int lat;
        ls_issue(1'b1, 3'b100, 32'h200, 32'hFFFFFFFF, lat);
        n_tests++;
        if (lat != 1 || ls_resp_err !== 1'b1 || ls_rdata !== 32'h0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL illegal_store: got lat %0d err %b data %h we %b want 1 1 0 0", lat, ls_resp_err, ls_rdata, mem_we);
        end
        tick();
        ls_issue(1'b0, 3'b011, 32'h100, 32'h0, lat);
        n_tests++;
        if (lat != 1 || ls_resp_err !== 1'b1 || ls_rdata !== 32'h0) begin
            n_fail++; $display("FAIL illegal_load: got lat %0d err %b data %h want 1 1 0", lat, ls_resp_err, ls_rdata);
        end
        tick();
        n_tests++;
        if (mem[12'h200] !== 8'hBE || ls_resp_err !== 1'b0) begin
            n_fail++; $display("FAIL illegal_side: got mem %h err %b want be 0", mem[12'h200], ls_resp_err);
        end
    endtask

    task automatic test_reset_mid();
        int resp_seen;
        ls_req_valid = 1'b1; ls_we = 1'b1; ls_sel = 3'b010; ls_addr = 32'h300; ls_wdata = 32'h11223344;
        #1;
        tick();
        ls_req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({ls_req_ready, if_req_ready, ls_resp_valid, if_resp_valid, ls_resp_err, mem_we,
             mem_addr, mem_wdata, ls_rdata, if_rdata} !== 110'h0) begin
            n_fail++; $display("FAIL reset_mid_out: got we %b addr %h wd %h v %b want all 0", mem_we, mem_addr, mem_wdata, ls_resp_valid);
        end
        rst_n = 1'b1;
        resp_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (ls_resp_valid || mem_we) resp_seen++;
            tick();
        end
        n_tests++;
        if (resp_seen != 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", resp_seen); end
        n_tests++;
        if ({mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]} !== 32'h11220000) begin
            n_fail++; $display("FAIL reset_mid_mem: got %h%h%h%h want 11220000", mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        mem[12'h100] <= 8'h80;
        mem[12'h101] <= 8'h12;
        mem[12'h102] <= 8'h34;
        mem[12'h103] <= 8'h56;
        #2;
        test_reset();
        test_arb_priority();
        test_both_held();
        test_loads();
        test_fetch();
        test_store_half();
        test_store_wrap();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Sequences and shares the single byte-wide data memory between two requesters: instruction fetch (IF, read-only, word) and load/store unit (LS, read/write, byte/half/word).
- Serialises multi-byte accesses one byte per cycle, big-endian (lowest address = MSB).
- Applies RISC-V funct3 sign/zero extension to read data.
- Sits between the core pipeline and the memory byte array.

Parameters:
- ADDR_W, 32: address width; byte address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- if_req_valid  in  1  IF request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  ADDR_W  IF word address.
- if_resp_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched word.
- ls_req_valid  in  1  LS request.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_we  in  1  1 = store, 0 = load.
- ls_sel  in  3  funct3.
- ls_addr  in  ADDR_W  byte address.
- ls_wdata  in  32  store data, right-aligned.
- ls_resp_valid  out  1  one-cycle pulse.
- ls_rdata  out  32  extended load data (0 for stores).
- ls_resp_err  out  1  illegal sel; qualified by ls_resp_valid.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_we  out  1  byte write strobe.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  combinational read of mem_addr, same cycle.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - All outputs are 0.
  - An in-flight transfer is aborted; bytes already written stay written; no response is issued.
- States: IDLE, XFER, RESP.
- IDLE:
  - When either valid is high, the arbiter picks a winner and drives that requester's ready = 1 for this cycle only (combinational on valid).
  - On acceptance: latch addr, sel, we, wdata and owner; clear byte index; go to XFER.
  - IF requests are always sel = 010, we = 0.
- XFER:
  - mem_addr = base + idx.
  - Load: shift mem_rdata into the assembly register.
  - Store: mem_we = 1; mem_wdata = byte (N-1-idx) of the right-aligned data, so MSB goes first.
  - Byte count N: 1 for 000/100, 2 for 001/101, 4 for 010.
  - After the byte with idx = N-1, go to RESP.
- RESP:
  - Owner's resp_valid = 1 for exactly one cycle.
  - rdata is sign-extended for 000/001 and zero-extended for 100/101.
  - Next state is IDLE. Both ready signals are 0 in RESP and XFER.
- Illegal sel:
  - Load: 011, 110, 111.
  - Store: any sel with bit2 = 1, or 011.
  - Go IDLE → RESP directly. No memory access; ls_rdata = 0, ls_resp_err = 1.
- Latency: accept at cycle T, response at T+N+1.
  - Back-to-back: the next acceptance is no earlier than the cycle after RESP.
- Outputs when idle: mem_we = 0, mem_addr = 0 outside XFER.
- Misalignment is not checked. Address crossing 2^ADDR_W wraps to 0.
- Requests are not queued. A requester must hold valid plus its fields until ready.

Optional Feature:
- ARB_RR_EN defined: two-way round-robin. The last granted owner gets lowest priority at the next simultaneous request. The pointer resets to "IF last", so LS wins first.
- ARB_RR_EN not defined: fixed priority, LS always wins over IF.

Decomposition:
- Package mem_port_pkg:
  - funct3 constants: SEL_B = 000, SEL_H = 001, SEL_W = 010, SEL_BU = 100, SEL_HU = 101.
  - State enum {IDLE, XFER, RESP}.
  - Owner enum {OWN_IF, OWN_LS}.
  - byte_count(sel) and sel_legal(sel, we) functions.
- One sub-module, mem_arb2: two-way grant logic, including the ARB_RR_EN pointer.

Test Plan:
- Memory preload for the load tests: mem[0x100..0x103] = 80, 12, 34, 56.
- LS load sel = 000 @ 0x100, accepted at T → ls_resp_valid at T+2, ls_rdata = 0xFFFFFF80.
- LS load sel = 101 @ 0x100 → 0x00008012 at T+3.
- IF fetch @ 0x100 → if_rdata = 0x80123456 at T+5; mem_addr steps 0x100..0x103.
- LS store sel = 001 @ 0x200, wdata 0xAAAABEEF → mem_we high T+1 and T+2; mem[0x200] = BE, mem[0x201] = EF; resp at T+3.
- Both valid in IDLE:
  - Fixed priority: LS granted, IF waits, then IF granted in the cycle after LS RESP.
  - With ARB_RR_EN and both held valid: grants alternate LS, IF, LS.
- Store sel = 100 → ls_resp_valid and ls_resp_err at T+1, no mem_we.
- Word store with rst_n low after 2 bytes → next cycle all outputs 0, no response; first 2 bytes written.
